// File: rtl/usb_data_tx.sv
// usb_data_tx: host-side ULPI transmit engine.
// Sends a DATA0/DATA1 packet on the ULPI link in this order:
// TX CMD carrying the PID, up to MAX_BYTES payload bytes, the CRC16 low
// and high bytes, and then one stp cycle.
// The PHY taking the bus (dir_i) before stp aborts the packet.
module usb_data_tx #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [3:0]             pid_i,
  input  logic [3:0]             len_i,
  input  logic [8*MAX_BYTES-1:0] payload_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   abort_o,
  input  logic                   dir_i,
  input  logic                   nxt_i,
  output logic [7:0]             data_o,
  output logic                   stp_o
);

  localparam logic [3:0] MaxLen = 4'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    TXCMD,
    DATA,
    CRC_LO,
    CRC_HI,
    STP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             pid_q, pid_d;
  logic [3:0]             len_q, len_d;
  logic [8*MAX_BYTES-1:0] payload_q, payload_d;
  logic [3:0]             idx_q, idx_d;
  logic [15:0]            crc_q, crc_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;

  logic [7:0]             curByte;
  logic [15:0]            txCrc;

  // USB CRC16 over one byte, bits taken LSB-first, poly 0x8005
  function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn,
                                            input logic [7:0]  b);
    logic [15:0] c;
    logic        fb;
    c = crcIn;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  // Select the payload byte at the current index; byte 0 sits in the top bits
  always_comb begin
    curByte = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (idx_q == 4'(i)) begin
        curByte = payload_q[8*(MAX_BYTES-1-i) +: 8];
      end
    end
  end

  // The transmitted CRC is the running register inverted and bit-reversed
  always_comb begin
    txCrc = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      txCrc[i] = ~crc_q[15-i];
    end
  end

  // Next-state logic and ULPI outputs; only cycles with nxt_i high advance the packet
  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    len_d     = len_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    data_o    = 8'h00;
    stp_o     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !dir_i) begin
          pid_d     = pid_i;
          len_d     = (len_i > MaxLen) ? MaxLen : len_i;
          payload_d = payload_i;
          crc_d     = 16'hFFFF;
          idx_d     = 4'd0;
          state_d   = TXCMD;
        end
      end
      TXCMD: begin
        data_o = {4'b0100, pid_q};
        if (dir_i) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (nxt_i) begin
          state_d = (len_q != 4'd0) ? DATA : CRC_LO;
        end
      end
      DATA: begin
        data_o = curByte;
        if (dir_i) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (nxt_i) begin
          crc_d = crc16Byte(crc_q, curByte);
          idx_d = idx_q + 4'd1;
          if (idx_q == len_q - 4'd1) begin
            state_d = CRC_LO;
          end
        end
      end
      CRC_LO: begin
        data_o = txCrc[7:0];
        if (dir_i) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (nxt_i) begin
          state_d = CRC_HI;
        end
      end
      CRC_HI: begin
        data_o = txCrc[15:8];
        if (dir_i) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (nxt_i) begin
          state_d = STP;
        end
      end
      STP: begin
        stp_o   = 1'b1;
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by active-low rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pid_q     <= 4'd0;
      len_q     <= 4'd0;
      payload_q <= '0;
      idx_q     <= 4'd0;
      crc_q     <= 16'hFFFF;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      len_q     <= len_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign ready_o = (state_q == IDLE) && !dir_i;
  assign done_o  = done_q;
  assign abort_o = abort_q;

endmodule
